// File: rtl/dpram_fifo_pkg.sv
// dpram_fifo_pkg: shared sizes, types and output-buffer states for the dpram FIFO controller
package dpram_fifo_pkg;
  localparam int AWIDTH = 10;
  localparam int DWIDTH = 36;
  localparam int DEPTH = 1024;
  typedef logic [AWIDTH-1:0] addr_t;
  typedef logic [DWIDTH-1:0] data_t;
  typedef logic [AWIDTH:0] cnt_t;
  typedef enum logic [1:0] {OB_EMPTY, OB_ONE, OB_TWO} ob_state_t;
endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// dpram_fifo_ctrl_if: stream handshakes plus RAM port-A/port-B bus of the FIFO controller
interface dpram_fifo_ctrl_if;
  import dpram_fifo_pkg::*;
  logic in_valid;
  logic in_ready;
  data_t in_data;
  logic out_valid;
  logic out_ready;
  data_t out_data;
  cnt_t count;
  logic wce_a;
  addr_t addr_a;
  data_t wd_a;
  logic rce_b;
  addr_t addr_b;
  data_t rq_b;
  modport slave (
    input in_valid, in_data, out_ready, rq_b,
    output in_ready, out_valid, out_data, count, wce_a, addr_a, wd_a, rce_b, addr_b
  );
  modport master (
    output in_valid, in_data, out_ready, rq_b,
    input in_ready, out_valid, out_data, count, wce_a, addr_a, wd_a, rce_b, addr_b
  );
endinterface

// File: rtl/dpram_fifo_outbuf.sv
// dpram_fifo_outbuf: 2-entry FWFT skid buffer absorbing RAM read data
module dpram_fifo_outbuf
  import dpram_fifo_pkg::*;
(
  input  logic       clock0,
  input  logic       reset,
  input  logic       wr_en_i,
  input  data_t      wdata_i,
  input  logic       pop_i,
  output logic       valid_o,
  output data_t      rdata_o,
  output logic [1:0] cnt_o
);
  ob_state_t st_q;
  data_t d0_q, d1_q;
  assign valid_o = st_q != OB_EMPTY;
  assign rdata_o = d0_q;
  assign cnt_o = st_q;
  always_ff @(posedge clock0) begin
    if (reset) begin
      st_q <= OB_EMPTY;
      d0_q <= '0;
      d1_q <= '0;
    end else begin
      unique case (st_q)
        OB_EMPTY: if (wr_en_i) begin
          d0_q <= wdata_i;
          st_q <= OB_ONE;
        end
        OB_ONE: begin
          if (wr_en_i && pop_i) d0_q <= wdata_i;
          if (wr_en_i) d1_q <= wdata_i;
          if (wr_en_i != pop_i) st_q <= wr_en_i ? OB_TWO : OB_EMPTY;
        end
        OB_TWO: if (pop_i) begin
          d0_q <= d1_q;
          d1_q <= wdata_i;
          st_q <= wr_en_i ? OB_TWO : OB_ONE;
        end
        default: st_q <= OB_EMPTY;
      endcase
    end
  end
  a_no_overflow: assert property (@(posedge clock0) disable iff (reset) !(wr_en_i && st_q == OB_TWO));
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FWFT FIFO controller driving a dual-port RAM with 1-cycle read latency
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
(
  input logic clock0,
  input logic reset,
  dpram_fifo_ctrl_if.slave bus
);
  addr_t wr_ptr_q, rd_ptr_q;
  cnt_t ram_cnt_q;
  logic inflight_q, push, pop, issue, ob_valid;
  logic [1:0] ob_cnt;
  logic [2:0] ob_occ;
  data_t ob_data;
  if (DEPTH != 2**AWIDTH) begin : g_depth_chk
    $error("DEPTH must equal 2**AWIDTH");
  end
  assign bus.in_ready = !reset && ram_cnt_q != cnt_t'(DEPTH);
  assign bus.out_valid = ob_valid;
  assign bus.out_data = ob_data;
  assign bus.wce_a = push;
  assign bus.addr_a = wr_ptr_q;
  assign bus.wd_a = bus.in_data;
  assign bus.rce_b = issue;
  assign bus.addr_b = rd_ptr_q;
  assign bus.count = ram_cnt_q + cnt_t'(inflight_q) + cnt_t'(ob_cnt);
  // ram_cnt_q excludes the word written this cycle, so a read never targets it
  always_comb begin
    push = bus.in_valid && bus.in_ready;
    pop = ob_valid && bus.out_ready;
    ob_occ = 3'(ob_cnt) + 3'(inflight_q) - 3'(pop);
    issue = !reset && ram_cnt_q != '0 && ob_occ < 3'd2;
  end
  always_ff @(posedge clock0) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ram_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + addr_t'(push);
      rd_ptr_q <= rd_ptr_q + addr_t'(issue);
      ram_cnt_q <= ram_cnt_q + cnt_t'(push) - cnt_t'(issue);
      inflight_q <= issue;
    end
  end
  dpram_fifo_outbuf u_outbuf (
    .clock0  (clock0),
    .reset   (reset),
    .wr_en_i (inflight_q),
    .wdata_i (bus.rq_b),
    .pop_i   (pop),
    .valid_o (ob_valid),
    .rdata_o (ob_data),
    .cnt_o   (ob_cnt)
  );
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: scoreboard bench with a behavioural dual-port RAM behind the controller
module tb_dpram_fifo_ctrl;
  import dpram_fifo_pkg::*;
  logic clock0 = 1'b0;
  logic reset = 1'b1;
  dpram_fifo_ctrl_if bus ();
  dpram_fifo_ctrl dut (.clock0(clock0), .reset(reset), .bus(bus.slave));
  always #5 clock0 = ~clock0;
  data_t mem [DEPTH];
  always @(posedge clock0) begin
    if (bus.wce_a) mem[bus.addr_a] <= bus.wd_a;
    if (bus.rce_b) bus.rq_b <= mem[bus.addr_b];
  end
  int checks = 0, errors = 0, n_push = 0, n_pop = 0, ram_model = 0, rce_bad = 0;
  data_t exp_q [$];
  data_t last_pop = '0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clock0) begin
    if (reset) begin
      exp_q.delete();
      ram_model = 0;
    end else begin
      chk("count", 64'(bus.count), 64'(exp_q.size()));
      if (bus.rce_b && ram_model == 0) rce_bad++;
      ram_model += int'(bus.in_valid && bus.in_ready) - int'(bus.rce_b);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        n_push++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("pop_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("data", 64'(bus.out_data), 64'(exp_q.pop_front()));
        last_pop = bus.out_data;
        n_pop++;
      end
    end
  end
  task automatic tick();
    @(posedge clock0);
    #1;
  endtask
  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 1200 && (exp_q.size() != 0 || bus.out_valid); i++) tick();
    chk("drained", 64'(exp_q.size()), 64'd0);
    bus.out_ready = 1'b0;
    tick();
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int p0, q0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_wce_a", 64'(bus.wce_a), 64'd0);
    chk("rst_rce_b", 64'(bus.rce_b), 64'd0);
    chk("rst_addr_a", 64'(bus.addr_a), 64'd0);
    chk("rst_addr_b", 64'(bus.addr_b), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data = 36'haaaaaaaaa;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_rce_e0", 64'(bus.rce_b), 64'd1);
    chk("t1_ov_e0", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t1_rce_e1", 64'(bus.rce_b), 64'd0);
    chk("t1_ov_e1", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t1_ov_e2", 64'(bus.out_valid), 64'd1);
    chk("t1_data", 64'(bus.out_data), 64'h0aaaaaaaaa);
    chk("t1_count", 64'(bus.count), 64'd1);
    drain();
    p0 = n_push;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      bus.in_data = DWIDTH'(i + 32'h1000);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t2_accepted", 64'(n_push - p0), 64'd1026);
    chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t2_count", 64'(bus.count), 64'd1026);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2 && !bus.in_ready; i++) tick();
    chk("t2_in_ready_back", 64'(bus.in_ready), 64'd1);
    drain();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    q0 = 0;
    for (int i = 0; i < 2000; i++) begin
      bus.in_data = DWIDTH'(i * 7 + 5);
      tick();
      if (i == 999) begin
        q0 = n_pop;
        chk("t3_count_mid", 64'(bus.count), 64'd3);
      end
    end
    chk("t3_rate", 64'(n_pop - q0), 64'd1000);
    chk("t3_count_end", 64'(bus.count), 64'd3);
    drain();
    p0 = n_push;
    for (int i = 0; i < 30000 && n_push - p0 < 5000; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data = DWIDTH'({$urandom, $urandom});
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t4_pushes", 64'(n_push - p0 >= 5000), 64'd1);
    drain();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = DWIDTH'(i + 32'h500);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_count", 64'(bus.count), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data = 36'h123456789;
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    q0 = n_pop;
    for (int i = 0; i < 10 && n_pop == q0; i++) tick();
    chk("t5_popped", 64'(n_pop - q0), 64'd1);
    chk("t5_first", 64'(last_pop), 64'h123456789);
    drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_rce_b", 64'(bus.rce_b), 64'd0);
      chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
    end
    bus.out_ready = 1'b0;
    chk("rce_guard", 64'(rce_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
